// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage with ALU, optional MUL/MULH and iterative divider, plus EX/MEM register.
// Optional multiply/divide hardware is enabled with EX_MULDIV_EN.
`default_nettype none

module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] reg_out_b_in,
    input  logic [4:0]      addr_rd_in,
    input  logic            reg_file_write_in,
    input  logic            mem_we_in,
    input  logic            mem_re_in,
    input  logic            branch_instruction_in,
    input  logic [1:0]      select_mux_4_in,
    input  logic [1:0]      select_mux_2_in,
    output logic            stall,
    output logic            valid_out,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] reg_out_b,
    output logic [4:0]      addr_rd_out,
    output logic            reg_file_write_out,
    output logic            mem_we_out,
    output logic            mem_re_out,
    output logic            branch_instruction_out,
    output logic            branch_out,
    output logic [1:0]      select_mux_4_out,
    output logic [1:0]      select_mux_2_out
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_MULH = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REM  = 4'd14;
    localparam logic [3:0] OP_REMU = 4'd15;

    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic            stall_int;
    logic            load;

    assign shamt = op_b[4:0];

`ifdef EX_MULDIV_EN
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            dvz_q, dvz_d;

    logic [2*XLEN-1:0] prod;
    logic            is_div;
    logic            div_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;
    logic [XLEN-1:0] div_res;
    logic            stall_div;

    // Low half of the sign-extended product is MUL; high half is signed MULH.
    assign prod = {{XLEN{op_a[XLEN-1]}}, op_a} * {{XLEN{op_b[XLEN-1]}}, op_b};

    assign is_div     = (alu_op[3:2] == 2'b11);
    assign div_signed = ~alu_op[0];
    assign a_neg      = div_signed & op_a[XLEN-1];
    assign b_neg      = div_signed & op_b[XLEN-1];
    assign a_mag      = a_neg ? (-op_a) : op_a;
    assign b_mag      = b_neg ? (-op_b) : op_b;

    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};

    assign q_fin   = dvz_q ? {XLEN{1'b1}} : (qneg_q ? (-quo_q) : quo_q);
    assign r_fin   = dvz_q ? dvd_q : (rneg_q ? (-rem_q) : rem_q);
    assign div_res = alu_op[1] ? r_fin : q_fin;

    always_comb begin
        state_d   = state_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        dvd_d     = dvd_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dvz_d     = dvz_q;
        stall_div = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_in && is_div) begin
                    stall_div = 1'b1;
                    state_d   = S_BUSY;
                    quo_d     = a_mag;
                    rem_d     = '0;
                    dvs_d     = b_mag;
                    dvd_d     = op_a;
                    qneg_d    = a_neg ^ b_neg;
                    rneg_d    = a_neg;
                    dvz_d     = (op_b == '0);
                    cnt_d     = CNT_INIT;
                end
            end
            S_BUSY: begin
                stall_div = 1'b1;
                cnt_d     = cnt_q - CNT_ONE;
                // Restoring step: keep the trial subtraction only when it does not go negative.
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (flush) begin
            state_d   = S_IDLE;
            stall_div = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dvz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dvz_q   <= dvz_d;
        end
    end

    assign stall_int = stall_div;
`else
    assign stall_int = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $signed(op_a) >>> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef EX_MULDIV_EN
            OP_MUL:  alu_res = prod[XLEN-1:0];
            OP_MULH: alu_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res = div_res;
`else
            OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res = '0;
`endif
            default: alu_res = '0;
        endcase
    end

    // Anything not loaded (idle slot, flush or stall) becomes an all-zero bubble.
    assign load  = valid_in & ~flush & ~stall_int;
    assign stall = stall_int & reset;

    logic            valid_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] store_q;
    logic [4:0]      rd_q;
    logic            rfw_q;
    logic            we_q;
    logic            re_q;
    logic            bri_q;
    logic            bro_q;
    logic [1:0]      m4_q;
    logic [1:0]      m2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            store_q <= '0;
            rd_q    <= '0;
            rfw_q   <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            bri_q   <= 1'b0;
            bro_q   <= 1'b0;
            m4_q    <= '0;
            m2_q    <= '0;
        end else begin
            valid_q <= load;
            alu_q   <= load ? alu_res : '0;
            store_q <= load ? reg_out_b_in : '0;
            rd_q    <= load ? addr_rd_in : '0;
            rfw_q   <= load & reg_file_write_in;
            we_q    <= load & mem_we_in;
            re_q    <= load & mem_re_in;
            bri_q   <= load & branch_instruction_in;
            bro_q   <= load & (alu_res == '0);
            m4_q    <= load ? select_mux_4_in : '0;
            m2_q    <= load ? select_mux_2_in : '0;
        end
    end

    assign valid_out              = valid_q;
    assign alu_out                = alu_q;
    assign reg_out_b              = store_q;
    assign addr_rd_out            = rd_q;
    assign reg_file_write_out     = rfw_q;
    assign mem_we_out             = we_q;
    assign mem_re_out             = re_q;
    assign branch_instruction_out = bri_q;
    assign branch_out             = bro_q;
    assign select_mux_4_out       = m4_q;
    assign select_mux_2_out       = m2_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for ex_stage; divider checks apply when EX_MULDIV_EN is defined.
`default_nettype none

module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] reg_out_b_in = '0;
    logic [4:0]  addr_rd_in = '0;
    logic        reg_file_write_in = 1'b0;
    logic        mem_we_in = 1'b0;
    logic        mem_re_in = 1'b0;
    logic        branch_instruction_in = 1'b0;
    logic [1:0]  select_mux_4_in = '0;
    logic [1:0]  select_mux_2_in = '0;
    logic        stall;
    logic        valid_out;
    logic [31:0] alu_out;
    logic [31:0] reg_out_b;
    logic [4:0]  addr_rd_out;
    logic        reg_file_write_out;
    logic        mem_we_out;
    logic        mem_re_out;
    logic        branch_instruction_out;
    logic        branch_out;
    logic [1:0]  select_mux_4_out;
    logic [1:0]  select_mux_2_out;

    int n_chk = 0;
    int n_fail = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .valid_in               (valid_in),
        .flush                  (flush),
        .alu_op                 (alu_op),
        .op_a                   (op_a),
        .op_b                   (op_b),
        .reg_out_b_in           (reg_out_b_in),
        .addr_rd_in             (addr_rd_in),
        .reg_file_write_in      (reg_file_write_in),
        .mem_we_in              (mem_we_in),
        .mem_re_in              (mem_re_in),
        .branch_instruction_in  (branch_instruction_in),
        .select_mux_4_in        (select_mux_4_in),
        .select_mux_2_in        (select_mux_2_in),
        .stall                  (stall),
        .valid_out              (valid_out),
        .alu_out                (alu_out),
        .reg_out_b              (reg_out_b),
        .addr_rd_out            (addr_rd_out),
        .reg_file_write_out     (reg_file_write_out),
        .mem_we_out             (mem_we_out),
        .mem_re_out             (mem_re_out),
        .branch_instruction_out (branch_instruction_out),
        .branch_out             (branch_out),
        .select_mux_4_out       (select_mux_4_out),
        .select_mux_2_out       (select_mux_2_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"}, 32'(valid_out), 32'd0);
        chk({tag, ".alu"}, alu_out, 32'd0);
        chk({tag, ".store"}, reg_out_b, 32'd0);
        chk({tag, ".rd"}, 32'(addr_rd_out), 32'd0);
        chk({tag, ".ctl"}, {26'd0, reg_file_write_out, mem_we_out, mem_re_out,
                            branch_instruction_out, branch_out, 1'b0}, 32'd0);
        chk({tag, ".mux"}, {28'd0, select_mux_4_out, select_mux_2_out}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        valid_in = 1'b1;
        flush    = 1'b0;
        alu_op   = o;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        op(o, a, b);
        step();
        chk({tag, ".alu"}, alu_out, exp);
        chk({tag, ".valid"}, 32'(valid_out), 32'd1);
        chk({tag, ".br"}, 32'(branch_out), 32'(exp == 32'd0));
    endtask

`ifdef EX_MULDIV_EN
    task automatic div_vec(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        op(o, a, b);
        #1;
        chk({tag, ".stall0"}, 32'(stall), 32'd1);
        cyc = 0;
        while (stall && cyc < 100) begin
            step();
            cyc++;
            if (stall) chk({tag, ".bubble_valid"}, 32'(valid_out), 32'd0);
        end
        chk({tag, ".stall_cycles"}, 32'(cyc), 32'd33);
        step();
        chk({tag, ".alu"}, alu_out, exp);
        chk({tag, ".valid"}, 32'(valid_out), 32'd1);
        valid_in = 1'b0;
        step();
        chk({tag, ".once"}, 32'(valid_out), 32'd0);
    endtask
`endif

    initial begin
        #1;
        reset = 1'b0;
`ifdef EX_MULDIV_EN
        op(4'd12, 32'd10, 32'd3);
`else
        op(4'd0, 32'd10, 32'd3);
`endif
        #1;
        chk("reset.stall", 32'(stall), 32'd0);
        step();
        step();
        chk_bubble("reset");
        valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        addr_rd_in = 5'd3;
        reg_file_write_in = 1'b1;
        alu_vec("add", 4'd0, 32'd5, 32'd7, 32'd12);
        chk("add.rd", 32'(addr_rd_out), 32'd3);
        chk("add.rfw", 32'(reg_file_write_out), 32'd1);
        reg_file_write_in = 1'b0;
        addr_rd_in = 5'd0;

        branch_instruction_in = 1'b1;
        alu_vec("sub", 4'd1, 32'd9, 32'd9, 32'd0);
        chk("sub.bri", 32'(branch_instruction_out), 32'd1);
        branch_instruction_in = 1'b0;

        alu_vec("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        alu_vec("or",  4'd3, 32'hF000_0001, 32'h0000_0010, 32'hF000_0011);
        alu_vec("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        alu_vec("sll", 4'd5, 32'd1, 32'd33, 32'd2);
        alu_vec("srl", 4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
        alu_vec("sra", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_vec("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_vec("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);

        reg_out_b_in = 32'hDEAD_BEEF;
        addr_rd_in = 5'd31;
        mem_we_in = 1'b1;
        mem_re_in = 1'b1;
        select_mux_4_in = 2'd2;
        select_mux_2_in = 2'd3;
        alu_vec("pass", 4'd0, 32'd100, 32'd4, 32'd104);
        chk("pass.store", reg_out_b, 32'hDEAD_BEEF);
        chk("pass.rd", 32'(addr_rd_out), 32'd31);
        chk("pass.ctl", {30'd0, mem_we_out, mem_re_out}, 32'd3);
        chk("pass.mux", {28'd0, select_mux_4_out, select_mux_2_out}, 32'hB);

        op(4'd0, 32'd1, 32'd1);
        valid_in = 1'b0;
        step();
        chk_bubble("novalid");

        op(4'd0, 32'd1, 32'd1);
        flush = 1'b1;
        step();
        chk_bubble("flush_alu");
        flush = 1'b0;

        alu_vec("pre_rst", 4'd0, 32'd5, 32'd7, 32'd12);
        #2;
        reset = 1'b0;
        #1;
        chk_bubble("async_rst");
        @(negedge clk);
        reset = 1'b1;
        reg_out_b_in = '0;
        addr_rd_in = '0;
        mem_we_in = 1'b0;
        mem_re_in = 1'b0;
        select_mux_4_in = '0;
        select_mux_2_in = '0;

`ifdef EX_MULDIV_EN
        alu_vec("mul", 4'd10, 32'd3, 32'd4, 32'd12);
        alu_vec("mulh_pos", 4'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        alu_vec("mulh_neg", 4'd11, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);

        div_vec("div", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        div_vec("rem", 4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        div_vec("divu0", 4'd13, 32'd55, 32'd0, 32'hFFFF_FFFF);
        div_vec("remu0", 4'd15, 32'd100, 32'd0, 32'd100);
        div_vec("div_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        div_vec("rem_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        div_vec("divu", 4'd13, 32'd100, 32'd7, 32'd14);
        div_vec("remu", 4'd15, 32'd100, 32'd7, 32'd2);

        op(4'd13, 32'd1000, 32'd3);
        step();
        for (int i = 0; i < 9; i++) step();
        chk("flushdiv.busy", 32'(stall), 32'd1);
        flush = 1'b1;
        #1;
        chk("flushdiv.stall", 32'(stall), 32'd0);
        step();
        chk_bubble("flushdiv");
        flush = 1'b0;
        op(4'd0, 32'd2, 32'd3);
        #1;
        chk("flushdiv.idle", 32'(stall), 32'd0);
        step();
        chk("flushdiv.add", alu_out, 32'd5);
        chk("flushdiv.valid", 32'(valid_out), 32'd1);

        op(4'd12, 32'd100, 32'd5);
        for (int i = 0; i < 5; i++) step();
        chk("rstdiv.busy", 32'(stall), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rstdiv.stall", 32'(stall), 32'd0);
        chk_bubble("rstdiv");
        @(negedge clk);
        reset = 1'b1;
        op(4'd9, 32'd1, 32'hFFFF_FFFF);
        #1;
        chk("rstdiv.idle", 32'(stall), 32'd0);
        step();
        chk("rstdiv.sltu", alu_out, 32'd1);
`else
        for (int o = 10; o < 16; o++) begin
            op(4'(o), 32'd3, 32'd4);
            #1;
            chk("nomd.stall", 32'(stall), 32'd0);
            step();
            chk("nomd.alu", alu_out, 32'd0);
            chk("nomd.valid", 32'(valid_out), 32'd1);
            chk("nomd.br", 32'(branch_out), 32'd1);
        end
        alu_vec("nomd.sltu", 4'd9, 32'd1, 32'hFFFF_FFFF, 32'd1);
`endif

        valid_in = 1'b0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline; sits directly upstream of the memory stage and contains the EX/MEM pipeline register.
- Single-cycle ALU, single-cycle multiplier and an iterative restoring divider.
- The divider stalls upstream stages while busy.
- Registered outputs feed the memory stage's alu_out, reg_out_b, addr_rd, write-enable and mux-select inputs.

Parameters:
- XLEN, 32, datapath width; the divider iterates XLEN cycles.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  ID/EX holds a real instruction.
- flush  in  1  kill the instruction in EX (branch taken downstream).
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULH, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- op_a, op_b  in  XLEN  ALU operands.
- reg_out_b_in  in  XLEN  store data.
- addr_rd_in  in  5  destination register.
- reg_file_write_in, mem_we_in, mem_re_in, branch_instruction_in  in  1  control, passed through.
- select_mux_4_in, select_mux_2_in  in  2  control, passed through.
- stall  out  1  combinational; hold PC, IF/ID and ID/EX.
- valid_out  out  1  registered.
- alu_out  out  XLEN  registered result.
- reg_out_b  out  XLEN  registered store data.
- addr_rd_out  out  5  registered.
- reg_file_write_out, mem_we_out, mem_re_out, branch_instruction_out  out  1  registered.
- branch_out  out  1  registered; result == 0.
- select_mux_4_out, select_mux_2_out  out  2  registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registered outputs go to 0.
  - FSM goes to IDLE; divider counter and registers clear.
  - stall=0 while reset is asserted.
- Non-divide ops (0-11): 1-cycle latency. An op presented in cycle N appears on the outputs after edge N.
- Shifts use op_b[4:0]. SLT/SLTU return 1 or 0.
- MUL returns the low XLEN bits. MULH returns the high XLEN bits of signed×signed.
- Divide FSM (ops 12-15):
  - IDLE: if valid_in & div op & !flush, stall=1. On the edge, latch operand magnitudes and signs, set count=XLEN, go to BUSY.
  - BUSY: stall=1. One restoring quotient bit per cycle; count decrements. At count reaching 0, go to DONE.
  - DONE: stall=0. The sign-corrected quotient or remainder drives alu_out. The edge latches EX/MEM (same instruction still held by upstream), then return to IDLE.
  - Total occupancy is XLEN+2 cycles (34 for XLEN=32).
- Stall cycles: the EX/MEM register loads a bubble so the memory stage never sees duplicates.
  - Bubble means valid_out=0, reg_file_write_out=0, mem_we_out=0, mem_re_out=0, branch_instruction_out=0, all data fields 0.
- Divide corner cases:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000; remainder = 0.
- flush=1 in any state:
  - EX/MEM loads a bubble on that edge.
  - FSM aborts to IDLE.
  - stall deasserts combinationally in the flush cycle.
- valid_in=0: treated as a bubble; the FSM does not start.
- branch_out = (result == 0), registered with the result.
- Reset mid-division: immediate abort; the outputs are bubbles.

Optional Feature:
- Macro: EX_MULDIV_EN.
- Defined: MUL, MULH and the divider FSM are present as specified.
- Undefined:
  - Ops 10-15 produce alu_out=0 with 1-cycle latency; control fields pass through normally.
  - No FSM is present; stall is tied to 0.

Test Plan:
- ADD op_a=5, op_b=7, addr_rd_in=3, reg_file_write_in=1 → next cycle alu_out=12, addr_rd_out=3, reg_file_write_out=1, branch_out=0.
- SUB 9-9 with branch_instruction_in=1 → alu_out=0, branch_out=1, branch_instruction_out=1.
- DIV op_a=-7, op_b=2 → stall high for 33 cycles, then alu_out=0xFFFFFFFD (-3) with valid_out=1 exactly once. REM with the same operands → 0xFFFFFFFF (-1).
- DIVU with op_b=0 → alu_out=0xFFFFFFFF. REMU 100/0 → 100. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- Start DIVU, assert flush in BUSY cycle 10:
  - stall drops that cycle and the next output is a bubble.
  - The following ADD completes in 1 cycle.
- Assert reset mid-division at cycle 5 → all outputs 0, stall=0. After release, SLTU 1<0xFFFFFFFF → alu_out=1.
